// File: rtl/i2c_master_ctrl.sv
// Single-master I2C controller: one-byte write or read per command, SCL from clk / (4*DIV).
// Optional feature macro: I2C_CLK_STRETCH_EN (honour slave clock stretching in q2).
module i2c_master_ctrl #(
    parameter int DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic       cmd_rw,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    output logic       busy,
    output logic [3:0] dbg_state,
    inout  wire        scl,
    inout  wire        sda
);
    localparam int QW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [QW-1:0] QMAX = QW'(DIV - 1);

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ACK1, WDATA, RDATA, ACK2, STOP, DONE
    } state_t;

    state_t        state, state_nx;
    logic [QW-1:0] qcnt;
    logic [1:0]    phase;
    logic [2:0]    bit_cnt;
    logic [7:0]    addr_byte, wdata_r, rx_sh;
    logic          nack_r, sda_low, sda_low_r, scl_low;
    logic          hold, accept, slot_end, sample_pt, sda_in;

    // Handshake: a command transfers on any cycle with cmd_valid && cmd_ready; the
    // response is a single-cycle rsp_valid pulse with rsp_rdata/rsp_nack valid alongside.
    assign cmd_ready = (state == IDLE) || (state == DONE);
    assign busy      = !cmd_ready;
    assign rsp_valid = (state == DONE);
    assign accept    = cmd_valid && cmd_ready;
    assign dbg_state = state;
    assign sda_in    = sda;

`ifdef I2C_CLK_STRETCH_EN
    assign hold = !cmd_ready && (phase == 2'd2) && !scl;
`else
    assign hold = 1'b0;
`endif

    assign slot_end  = (phase == 2'd3) && (qcnt == QMAX) && !hold;
    assign sample_pt = (phase == 2'd2) && (qcnt == QMAX) && !hold;

    assign scl = scl_low ? 1'b0 : 1'bz;
    assign sda = sda_low ? 1'b0 : 1'bz;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            qcnt      <= '0;
            phase     <= 2'd0;
            bit_cnt   <= 3'd7;
            addr_byte <= 8'h00;
            wdata_r   <= 8'h00;
            rx_sh     <= 8'h00;
            nack_r    <= 1'b0;
            sda_low_r <= 1'b0;
            rsp_rdata <= 8'h00;
            rsp_nack  <= 1'b0;
        end else begin
            state     <= state_nx;
            sda_low_r <= sda_low;
            if (cmd_ready) begin
                qcnt  <= '0;
                phase <= 2'd0;
            end else if (!hold) begin
                if (qcnt == QMAX) begin
                    qcnt  <= '0;
                    phase <= phase + 2'd1;
                end else begin
                    qcnt <= qcnt + 1'b1;
                end
            end
            if (accept) begin
                addr_byte <= {cmd_addr, cmd_rw};
                wdata_r   <= cmd_wdata;
                bit_cnt   <= 3'd7;
                rx_sh     <= 8'h00;
                nack_r    <= 1'b0;
            end
            // Counter wraps 0 -> 7, so it is already primed for the data byte after ADDR.
            if (slot_end && (state == ADDR || state == WDATA || state == RDATA))
                bit_cnt <= bit_cnt - 3'd1;
            if (sample_pt) begin
                if (state == RDATA) rx_sh <= {rx_sh[6:0], sda_in};
                if (state == ACK1 && sda_in) nack_r <= 1'b1;
                if (state == ACK2 && !addr_byte[0] && sda_in) nack_r <= 1'b1;
            end
            if (state == STOP && slot_end) begin
                rsp_nack  <= nack_r;
                rsp_rdata <= (addr_byte[0] && !nack_r) ? rx_sh : 8'h00;
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (accept) state_nx = START;
            START: if (slot_end) state_nx = ADDR;
            ADDR:  if (slot_end && bit_cnt == 3'd0) state_nx = ACK1;
            ACK1:  if (slot_end) state_nx = nack_r ? STOP : (addr_byte[0] ? RDATA : WDATA);
            WDATA: if (slot_end && bit_cnt == 3'd0) state_nx = ACK2;
            RDATA: if (slot_end && bit_cnt == 3'd0) state_nx = ACK2;
            ACK2:  if (slot_end) state_nx = STOP;
            STOP:  if (slot_end) state_nx = DONE;
            DONE:  state_nx = accept ? START : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // SDA only moves at the start of q1 (SCL low); q0 repeats the previous slot's level.
    always_comb begin
        scl_low = 1'b0;
        sda_low = 1'b0;
        unique case (state)
            START: begin
                scl_low = (phase == 2'd3);
                sda_low = (phase != 2'd0);
            end
            ADDR: begin
                scl_low = (phase < 2'd2);
                sda_low = (phase == 2'd0) ? sda_low_r : !addr_byte[bit_cnt];
            end
            WDATA: begin
                scl_low = (phase < 2'd2);
                sda_low = (phase == 2'd0) ? sda_low_r : !wdata_r[bit_cnt];
            end
            ACK1, RDATA, ACK2: begin
                scl_low = (phase < 2'd2);
                sda_low = (phase == 2'd0) ? sda_low_r : 1'b0;
            end
            STOP: begin
                scl_low = (phase < 2'd2);
                sda_low = (phase == 2'd0) ? sda_low_r : (phase != 2'd3);
            end
            default: begin
                scl_low = 1'b0;
                sda_low = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl with a bus monitor and an ACKing slave at 0x66.
// Define I2C_CLK_STRETCH_EN for both files to add the clock-stretch step.
module tb_i2c_master_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [6:0] cmd_addr = 7'h00;
    logic       cmd_rw = 1'b0;
    logic [7:0] cmd_wdata = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_nack;
    logic       busy;
    logic [3:0] dbg_state;
    wire        scl;
    wire        sda;

    logic slv_low = 1'b0;
    logic slv_scl_low = 1'b0;
    assign sda = slv_low ? 1'b0 : 1'bz;
    assign scl = slv_scl_low ? 1'b0 : 1'bz;
    pullup (sda);
    pullup (scl);

    i2c_master_ctrl #(.DIV(4)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_rw(cmd_rw), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack),
        .busy(busy), .dbg_state(dbg_state), .scl(scl), .sda(sda)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [15:0] exp_q[$];
    logic [15:0] obs_q[$];

    // Bus monitor plus slave model, evaluated on the falling clock edge.
    logic       scl_d = 1'b1, sda_d = 1'b1;
    int         rises = 0, starts = 0, stops = 0, stop_rise = 0;
    logic [7:0] m_addr = 8'h00, m_data = 8'h00;
    logic       m_ack2 = 1'b1;
    logic [7:0] slv_rdata = 8'h3C;
    initial begin
        forever begin
            logic scl_v, sda_v, match;
            @(negedge clk);
            scl_v = (scl !== 1'b0);
            sda_v = (sda !== 1'b0);
            match = (m_addr[7:1] == 7'h66);
            if (scl_d && scl_v && sda_d && !sda_v) begin
                starts++;
                rises = 0; m_addr = 8'h00; m_data = 8'h00; m_ack2 = 1'b1; slv_low = 1'b0;
            end else if (scl_d && scl_v && !sda_d && sda_v) begin
                stops++;
                stop_rise = rises;
                obs_q.push_back({m_addr, m_data});
            end else if (!scl_d && scl_v) begin
                rises++;
                if (rises <= 8) m_addr = {m_addr[6:0], sda_v};
                else if (rises >= 10 && rises <= 17) m_data = {m_data[6:0], sda_v};
                else if (rises == 18) m_ack2 = sda_v;
            end else if (scl_d && !scl_v) begin
                if (rises == 8) slv_low = match;
                else if (match && m_addr[0] && rises >= 9 && rises <= 16) slv_low = !slv_rdata[16 - rises];
                else if (match && !m_addr[0] && rises == 17) slv_low = 1'b1;
                else slv_low = 1'b0;
            end
            scl_d = scl_v;
            sda_d = sda_v;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [6:0] a, input logic r, input logic [7:0] d);
        cmd_addr = a; cmd_rw = r; cmd_wdata = d; cmd_valid = 1'b1;
        check("accept_ready", cmd_ready, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cyc = 1;
        check("ready_drop", cmd_ready, 0);
    endtask

    task automatic wait_rsp(input string tag, input int exp_lat);
        while (rsp_valid !== 1'b1 && cyc < 3000) tick();
        check({tag, "_latency"}, cyc, exp_lat);
    endtask

    task automatic check_rsp(input string tag, input logic nack, input logic [7:0] rd,
                             input int srise, input logic ack2);
        logic [15:0] o, e;
        check({tag, "_rsp_valid"}, rsp_valid, 1);
        check({tag, "_rsp_nack"}, rsp_nack, nack);
        check({tag, "_rsp_rdata"}, rsp_rdata, rd);
        check({tag, "_ready_in_done"}, cmd_ready, 1);
        check({tag, "_stop_after_rise"}, stop_rise, srise);
        check({tag, "_ack2_level"}, m_ack2, ack2);
        check({tag, "_bus_count"}, obs_q.size(), 1);
        if (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_bus_bytes"}, o, e);
        end
    endtask

    initial begin
        int s0, p0;
        repeat (3) tick();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 8'h00);
        check("rst_rsp_nack", rsp_nack, 0);
        check("rst_scl", scl, 1);
        check("rst_sda", sda, 1);
        rst = 1'b0;
        tick();

        // Write 0xA5 to 0x66
        exp_q.push_back({8'hCC, 8'hA5});
        send(7'h66, 1'b0, 8'hA5);
        wait_rsp("wr", 321);
        check_rsp("wr", 1'b0, 8'h00, 19, 1'b0);
        tick();
        check("wr_pulse_one_cycle", rsp_valid, 0);

        // Read 0x3C from 0x66; master leaves SDA high in ACK2
        exp_q.push_back({8'hCD, 8'h3C});
        send(7'h66, 1'b1, 8'hFF);
        wait_rsp("rd", 321);
        check_rsp("rd", 1'b0, 8'h3C, 19, 1'b1);
        tick();

        // Nobody at 0x12: STOP straight after ACK1
        exp_q.push_back({8'h24, 8'h00});
        send(7'h12, 1'b0, 8'h77);
        wait_rsp("nack", 177);
        check_rsp("nack", 1'b1, 8'h00, 10, 1'b1);
        tick();

        // Reset during ADDR bit 3 (cycles 81..96 after accept)
        send(7'h66, 1'b0, 8'h99);
        while (cyc < 86) tick();
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        tick();
        check("mid_rst_scl", scl, 1);
        check("mid_rst_sda", sda, 1);
        check("mid_rst_ready", cmd_ready, 1);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        rst = 1'b0;
        repeat (3) begin
            tick();
            check("post_rst_no_rsp", rsp_valid, 0);
        end
        check("post_rst_no_bus_stop", obs_q.size(), 0);
        exp_q.push_back({8'hCC, 8'h5A});
        send(7'h66, 1'b0, 8'h5A);
        wait_rsp("after_rst", 321);
        check_rsp("after_rst", 1'b0, 8'h00, 19, 1'b0);
        tick();

        // Back-to-back: cmd_valid held across both commands
        s0 = starts;
        p0 = stops;
        exp_q.push_back({8'hCC, 8'h0F});
        exp_q.push_back({8'hCD, 8'h3C});
        cmd_addr = 7'h66; cmd_rw = 1'b0; cmd_wdata = 8'h0F; cmd_valid = 1'b1;
        check("b2b_first_ready", cmd_ready, 1);
        @(posedge clk);
        #1;
        cyc = 1;
        cmd_rw = 1'b1;
        cmd_wdata = 8'h00;
        wait_rsp("b2b1", 321);
        check_rsp("b2b1", 1'b0, 8'h00, 19, 1'b0);
        @(posedge clk);
        #1;
        cyc = 1;
        cmd_valid = 1'b0;
        check("b2b_second_taken", busy, 1);
        wait_rsp("b2b2", 321);
        check_rsp("b2b2", 1'b0, 8'h3C, 19, 1'b1);
        check("b2b_sda_edges_scl_high_start", starts - s0, 2);
        check("b2b_sda_edges_scl_high_stop", stops - p0, 2);
        tick();

`ifdef I2C_CLK_STRETCH_EN
        // Slave holds SCL low for the first 50 clocks of ACK1 q2 (cycles 153..202)
        exp_q.push_back({8'hCC, 8'hA5});
        send(7'h66, 1'b0, 8'hA5);
        while (cyc < 152) tick();
        slv_scl_low = 1'b1;
        while (cyc < 203) tick();
        slv_scl_low = 1'b0;
        wait_rsp("stretch", 371);
        check_rsp("stretch", 1'b0, 8'h00, 19, 1'b0);
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
